// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces hsync/vsync/blank, pixel coordinates and line/frame strobes
// from free-running horizontal/vertical counters, with optional pixel
// repetition through a clock prescaler (PIX_REP clocks per pixel).
// Build option: define VGA_TIMING_PATTERN_EN to add a registered test
// pattern on vr/vg/vb; without it those ports and their logic are absent.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 64,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 200,
  parameter int V_ACTIVE = 800,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 24,
  parameter int H_POL    = 0,
  parameter int V_POL    = 1,
  parameter int PIX_REP  = 1,
  parameter int CW       = 12
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [4:0]    vr,
  output logic [4:0]    vg,
  output logic [4:0]    vb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] ONE    = CW'(1);

  localparam logic       HS_ON    = (H_POL != 0);
  localparam logic       VS_ON    = (V_POL != 0);
  localparam logic [1:0] PRE_LAST = 2'(PIX_REP - 1);

  logic [1:0]    pre_q, pre_d;
  logic          ce;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic [CW-1:0] hpos_q, hpos_d;
  logic [CW-1:0] vpos_q, vpos_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_q, blank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Prescaler: one pixel strobe every PIX_REP clocks while enabled.
  always_comb begin
    ce    = en && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (en) begin
      pre_d = (pre_q == PRE_LAST) ? 2'd0 : pre_q + 2'd1;
    end
  end

  // pix_ce is the strobe itself rather than a registered copy, so that with
  // PIX_REP=1 it tracks en and fires in the very first clock after reset.
  assign pix_ce = ce && !rst;

  // Raster counters: h wraps at end of line, v advances on every h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
      end else begin
        h_cnt_d = h_cnt_q + ONE;
      end
    end
  end

  // Output decode: all outputs sample the same counter value on a pixel
  // strobe, so coordinates, blank and syncs always describe one pixel.
  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (ce) begin
      hpos_d        = h_cnt_q;
      vpos_d        = v_cnt_q;
      hsync_d       = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_ON : ~HS_ON;
      vsync_d       = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_ON : ~VS_ON;
      blank_d       = (h_cnt_q >= H_ACT) || (v_cnt_q >= V_ACT);
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // State and output registers; reset drops any partial line or sync pulse.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pre_q         <= 2'd0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_PATTERN_EN
  // Counter bits 9..4 feed the pattern; bits above CW read as zero so
  // narrow counter configurations still elaborate.
  logic [9:4] h_hi;
  logic [9:4] v_hi;
  logic [4:0] pat_b;
  logic [4:0] vr_q, vr_d;
  logic [4:0] vg_q, vg_d;
  logic [4:0] vb_q, vb_d;

  for (genvar gi = 4; gi < 10; gi++) begin : g_hi_bits
    if (gi < CW) begin : g_used
      assign h_hi[gi] = h_cnt_q[gi];
      assign v_hi[gi] = v_cnt_q[gi];
    end else begin : g_zero
      assign h_hi[gi] = 1'b0;
      assign v_hi[gi] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_pat_b
    assign pat_b[gi] = h_hi[gi+5] ^ v_hi[gi+5];
  end

  // Pattern colour for the pixel being decoded; black while blanked.
  always_comb begin
    vr_d = vr_q;
    vg_d = vg_q;
    vb_d = vb_q;
    if (ce) begin
      if (blank_d) begin
        vr_d = 5'd0;
        vg_d = 5'd0;
        vb_d = 5'd0;
      end else begin
        vr_d = v_hi[8:4];
        vg_d = h_hi[8:4];
        vb_d = pat_b;
      end
    end
  end

  // Pattern registers, aligned with hpos/vpos.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vr_q <= 5'd0;
      vg_q <= 5'd0;
      vb_q <= 5'd0;
    end else begin
      vr_q <= vr_d;
      vg_q <= vg_d;
      vb_q <= vb_d;
    end
  end

  assign vr = vr_q;
  assign vg = vg_q;
  assign vb = vb_q;
`else
  // No pattern outputs in this build; timing outputs are unchanged.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen on three instances:
// default 1280x800 timing, default horizontal with a short vertical frame,
// and a tiny PIX_REP=3 mode.
module tb_vga_timing_gen;
  localparam int CW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          d_rst, d_en, d_pix_ce, d_hsync, d_vsync, d_blank, d_ls, d_fs;
  logic [CW-1:0] d_hpos, d_vpos;
  logic          m_rst, m_en, m_pix_ce, m_hsync, m_vsync, m_blank, m_ls, m_fs;
  logic [CW-1:0] m_hpos, m_vpos;
  logic          s_rst, s_en, s_pix_ce, s_hsync, s_vsync, s_blank, s_ls, s_fs;
  logic [CW-1:0] s_hpos, s_vpos;
`ifdef VGA_TIMING_PATTERN_EN
  logic [4:0] d_vr, d_vg, d_vb, m_vr, m_vg, m_vb, s_vr, s_vg, s_vb;
`endif

  vga_timing_gen dut_d (
    .pixel_clk(clk), .rst(d_rst), .en(d_en), .pix_ce(d_pix_ce),
    .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank),
    .hpos(d_hpos), .vpos(d_vpos), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_PATTERN_EN
    , .vr(d_vr), .vg(d_vg), .vb(d_vb)
`endif
  );

  vga_timing_gen #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(3), .V_BP(2)) dut_m (
    .pixel_clk(clk), .rst(m_rst), .en(m_en), .pix_ce(m_pix_ce),
    .hsync(m_hsync), .vsync(m_vsync), .blank(m_blank),
    .hpos(m_hpos), .vpos(m_vpos), .line_start(m_ls), .frame_start(m_fs)
`ifdef VGA_TIMING_PATTERN_EN
    , .vr(m_vr), .vg(m_vg), .vb(m_vb)
`endif
  );

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .PIX_REP(3)) dut_s (
    .pixel_clk(clk), .rst(s_rst), .en(s_en), .pix_ce(s_pix_ce),
    .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank),
    .hpos(s_hpos), .vpos(s_vpos), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_PATTERN_EN
    , .vr(s_vr), .vg(s_vg), .vb(s_vb)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_start, hs_len, blank_rise, ls_t, seq_err, fs_extra, b_before, b_after;
    int eh, ev, budget, frz_err, hs_early;
    int fs_n, fs_t0, fs_t1, fs_t2, vs_first, vs_cnt, vbl_err, bfall_err, last_h, last_v;
    int ce_err, ce_n, s_ls0, s_ls1, s_fs0, s_fs1, s_seq_err;
    int p_vr, p_vg, p_vb, q_vr, q_vg, q_vb;
    hs_start = -1; hs_len = 0; blank_rise = -1; ls_t = -1; seq_err = 0; fs_extra = 0;
    b_before = -1; b_after = -1; eh = 0; ev = 0; frz_err = 0; hs_early = 0;
    fs_n = 0; fs_t0 = -1; fs_t1 = -1; fs_t2 = -1; vs_first = -1; vs_cnt = 0;
    vbl_err = 0; bfall_err = 0; last_h = -1; last_v = -1;
    ce_err = 0; ce_n = 0; s_ls0 = -1; s_ls1 = -1; s_fs0 = -1; s_fs1 = -1; s_seq_err = 0;
    p_vr = -1; p_vg = -1; p_vb = -1; q_vr = -1; q_vg = -1; q_vb = -1;

    d_rst = 1'b1; m_rst = 1'b1; s_rst = 1'b1;
    d_en  = 1'b1; m_en  = 1'b1; s_en  = 1'b1;
    repeat (3) tick();

    // Reset state of the default instance.
    check("rst_hpos", d_hpos, 0);
    check("rst_vpos", d_vpos, 0);
    check("rst_blank", d_blank, 1);
    check("rst_hsync", d_hsync, 1);
    check("rst_vsync", d_vsync, 0);
    check("rst_pix_ce", d_pix_ce, 0);
    check("rst_line_start", d_ls, 0);
    check("rst_frame_start", d_fs, 0);

    // First clock with reset low carries the first pixel strobe.
    d_rst = 1'b0;
    #1;
    check("first_pix_ce", d_pix_ce, 1);
    tick();
    check("first_hpos", d_hpos, 0);
    check("first_vpos", d_vpos, 0);
    check("first_blank", d_blank, 0);
    check("first_frame_start", d_fs, 1);
    check("first_line_start", d_ls, 1);

    // Two full lines of the default mode.
    for (int c = 0; c < 2 * 1680; c++) begin
      if (c > 0) tick();
      if (int'(d_hpos) != eh || int'(d_vpos) != ev) seq_err++;
      if (ev == 0) begin
        if (d_hsync == 1'b0) begin
          if (hs_start < 0) hs_start = int'(d_hpos);
          hs_len++;
        end
        if (d_blank && blank_rise < 0) blank_rise = int'(d_hpos);
      end
      if (d_ls && c > 0 && ls_t < 0) ls_t = c;
      if (d_fs && c > 0) fs_extra++;
      if (c == 1679) b_before = int'(d_blank);
      if (c == 1680) b_after = int'(d_blank);
`ifdef VGA_TIMING_PATTERN_EN
      if (c == 1680 + 304) begin p_vr = int'(d_vr); p_vg = int'(d_vg); p_vb = int'(d_vb); end
      if (c == 1680 + 1300) begin q_vr = int'(d_vr); q_vg = int'(d_vg); q_vb = int'(d_vb); end
`endif
      eh++;
      if (eh == 1680) begin eh = 0; ev++; end
    end
    check("hsync_start_hpos", hs_start, 1344);
    check("hsync_width", hs_len, 136);
    check("blank_rise_hpos", blank_rise, 1280);
    check("line_period", ls_t, 1680);
    check("hv_sequence_err", seq_err, 0);
    check("frame_start_extra", fs_extra, 0);
    check("blank_before_wrap", b_before, 1);
    check("blank_after_wrap", b_after, 0);
`ifdef VGA_TIMING_PATTERN_EN
    check("pat_vr_active", p_vr, 0);
    check("pat_vg_active", p_vg, 19);
    check("pat_vb_active", p_vb, 9);
    check("pat_vr_blank", q_vr, 0);
    check("pat_vg_blank", q_vg, 0);
    check("pat_vb_blank", q_vb, 0);
`endif

    // Freeze at (100,5) for 50 clocks.
    budget = 0;
    do begin tick(); budget++; end
    while (!(d_hpos == 12'd100 && d_vpos == 12'd5) && budget < 10000);
    check("reach_100_5", int'(budget < 10000), 1);
    d_en = 1'b0;
    #1;
    check("freeze_pix_ce", d_pix_ce, 0);
    repeat (50) begin
      tick();
      if (d_hpos != 12'd100 || d_vpos != 12'd5 || d_pix_ce || d_ls || d_fs ||
          d_blank || !d_hsync || d_vsync) frz_err++;
    end
    check("freeze_hold_err", frz_err, 0);
    d_en = 1'b1;
    tick();
    check("resume_hpos", d_hpos, 101);
    check("resume_vpos", d_vpos, 5);

    // One-clock reset in mid-frame at hpos=700.
    budget = 0;
    do begin tick(); budget++; end
    while (d_hpos != 12'd700 && budget < 2000);
    check("reach_700", int'(budget < 2000), 1);
    d_rst = 1'b1;
    tick();
    check("mid_rst_hpos", d_hpos, 0);
    check("mid_rst_vpos", d_vpos, 0);
    check("mid_rst_blank", d_blank, 1);
    check("mid_rst_hsync", d_hsync, 1);
    check("mid_rst_vsync", d_vsync, 0);
    check("mid_rst_strobes", {d_pix_ce, d_ls, d_fs}, 0);
    d_rst = 1'b0;
    tick();
    check("post_rst_hpos", d_hpos, 0);
    check("post_rst_vpos", d_vpos, 0);
    check("post_rst_frame_start", d_fs, 1);
    repeat (1343) begin
      tick();
      if (!d_hsync) hs_early++;
    end
    check("no_early_hsync", hs_early, 0);
    check("pre_sync_hpos", d_hpos, 1343);
    tick();
    check("sync_at_1344", d_hsync, 0);
    d_rst = 1'b1;

    // Short vertical frame: vsync, vertical blanking, frame period.
    tick();
    m_rst = 1'b0;
    tick();
    for (int c = 0; c <= 2 * 20160; c++) begin
      if (c > 0) tick();
      if (m_fs) begin
        if (fs_n == 0) fs_t0 = c;
        else if (fs_n == 1) fs_t1 = c;
        else if (fs_n == 2) fs_t2 = c;
        fs_n++;
      end
      if (c < 20160 && m_vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
      if (m_vpos >= 12'd6 && !m_blank) vbl_err++;
      if (m_vpos < 12'd6 && m_hpos == 12'd0 && m_blank) bfall_err++;
      if (c == 20159) begin last_h = int'(m_hpos); last_v = int'(m_vpos); end
    end
    check("frame_start_count", fs_n, 3);
    check("frame_start_t0", fs_t0, 0);
    check("frame_period_1", fs_t1 - fs_t0, 20160);
    check("frame_period_2", fs_t2 - fs_t1, 20160);
    check("vsync_first_clk", vs_first, 7 * 1680);
    check("vsync_clks", vs_cnt, 3 * 1680);
    check("vblank_err", vbl_err, 0);
    check("blank_fall_err", bfall_err, 0);
    check("frame_last_hpos", last_h, 1679);
    check("frame_last_vpos", last_v, 11);
    m_rst = 1'b1;

    // PIX_REP=3 mode: strobe cadence, 3-clock pixel hold, line/frame period.
    tick();
    s_rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) tick();
      else #1;
      if (s_pix_ce) ce_n++;
      if (s_pix_ce != ((c % 3) == 2)) ce_err++;
      if (c >= 3) begin
        if (int'(s_hpos) != ((c - 3) / 3) % 14 || int'(s_vpos) != ((c - 3) / 42) % 7)
          s_seq_err++;
      end
      if (s_ls) begin
        if (s_ls0 < 0) s_ls0 = c;
        else if (s_ls1 < 0) s_ls1 = c;
      end
      if (s_fs) begin
        if (s_fs0 < 0) s_fs0 = c;
        else if (s_fs1 < 0) s_fs1 = c;
      end
    end
    check("rep3_pix_ce_count", ce_n, 100);
    check("rep3_pix_ce_err", ce_err, 0);
    check("rep3_seq_err", s_seq_err, 0);
    check("rep3_first_line", s_ls0, 3);
    check("rep3_line_period", s_ls1 - s_ls0, 42);
    check("rep3_frame_period", s_fs1 - s_fs0, 294);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
